// File: rtl/apb_req_arbiter_pkg.sv
// rtl/apb_req_arbiter_pkg.sv - shared APB arbiter types and constants
// Purpose: FSM state encoding, APB slave count and grant-index width shared
//          by the arbiter top and the round-robin picker.
// Ports:   none (package).
package apb_req_arbiter_pkg;

    localparam int NSLV  = 4;   // number of APB slaves, one psel bit each
    localparam int IDX_W = 2;   // width of requester / slave indices

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr_picker.sv
// rtl/apb_req_arbiter_rr_picker.sv - round-robin winner selection
// Purpose: pick the first asserted request at or after (last + 1) mod NREQ.
// Ports:   req   - request vector to choose from
//          last  - index of the previous grant
//          valid - at least one request asserted
//          idx   - winning requester index
module rr_picker
    import apb_req_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Outer loop walks distance from the last grant, inner loop keeps every
    // bit select constant so no variable indexing is needed.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] && (((int'(last) + k) % NREQ) == i)) begin
                    valid = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter of NREQ requesters onto one APB master
// Purpose: grants one requester at a time, runs a SETUP/ACCESS APB transfer to
//          the requested slave and returns data/error with a one-cycle done pulse.
// Ports:   clk, rst_n                     - clock, async active-low reset
//          req_valid/write/slave/addr/wdata - per-requester packed requests
//          req_done, rsp_rdata, rsp_error - completion pulse and response
//          psel, penable, pwrite, paddr, pwdata - APB master request
//          prdata, pready, pslverr        - APB slave response
//          grant_id                       - current / last owner
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [2*NREQ-1:0]      req_slave,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [DATA_W*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]        req_done,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_error,
    output logic [NSLV-1:0]        psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDR_W-1:0]      paddr,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [DATA_W-1:0]      prdata,
    input  logic                   pready,
    input  logic                   pslverr,
    output logic [IDX_W-1:0]       grant_id
);

    localparam int TW = $clog2(TIMEOUT + 1);

    apb_state_e       state, state_nxt;
    logic [TW-1:0]    tcnt;
    logic [IDX_W-1:0] slave_q;
    logic [NREQ-1:0]  owner_mask;
    logic [NREQ-1:0]  pick_req;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             grant, done, timed_out;
    logic             sel_write;
    logic [IDX_W-1:0] sel_slave;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (pick_req),
        .last  (grant_id),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_mask = NREQ'(1) << grant_id;

    // Fields of the winning requester, captured only on grant.
    always_comb begin
        sel_write = 1'b0;
        sel_slave = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_slave = req_slave[2*i +: 2];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The timeout fires in the ACCESS cycle whose pready=0 would bring the
    // wait count to TIMEOUT, so exactly TIMEOUT ACCESS cycles are spent.
    always_comb begin
        state_nxt = state;
        pick_req  = '0;
        grant     = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            ST_IDLE: begin
                pick_req = req_valid;
                if (pick_valid) begin
                    grant     = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                timed_out = !pready && (tcnt == TW'(TIMEOUT - 1));
                done      = pready || timed_out;
                if (done) begin
                    // Finishing owner is excluded so others get the next slot.
                    pick_req = req_valid & ~owner_mask;
                    if (pick_valid) begin
                        grant     = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            grant_id <= IDX_W'(NREQ - 1);
            slave_q  <= '0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                tcnt     <= '0;
                grant_id <= pick_idx;
                slave_q  <= sel_slave;
                pwrite   <= sel_write;
                paddr    <= sel_addr;
                pwdata   <= sel_wdata;
            end else if (state == ST_ACCESS && !pready) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    always_comb begin
        psel = '0;
        if (state != ST_IDLE) psel[slave_q] = 1'b1;
    end

    assign penable   = (state == ST_ACCESS);
    assign req_done  = done ? owner_mask : '0;
    assign rsp_error = done && (timed_out || pslverr);
    assign rsp_rdata = (done && pready && !pwrite) ? prdata : '0;

endmodule
